// File: rtl/dp_operand_sequencer.sv
// dp_operand_sequencer: serial (x,y) FP32 pairs in, 4-lane groups out to the
// dot-product pipe, tagged z results back through a credit-guarded FIFO.
//
// Ports:
//   clk, rst             rising-edge clock, async active-low reset
//   in_valid/in_ready    operand pair handshake
//   in_x, in_y           FP32 pair
//   in_last              pair closes the group early
//   in_mode              group op, taken from the first pair of a group
//   dp_op, dp_x*, dp_y*  registered operand bus to the pipe
//   dp_z                 pipe result, valid PIPE_LAT edges after operands
//   out_valid/out_ready  result handshake
//   out_z, out_tag       FIFO head result and its group tag
//   busy                 partial group, in-flight group or unread result
module dp_operand_sequencer #(
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             dp_op,
  output logic [31:0]      dp_x0,
  output logic [31:0]      dp_x1,
  output logic [31:0]      dp_x2,
  output logic [31:0]      dp_x3,
  output logic [31:0]      dp_y0,
  output logic [31:0]      dp_y1,
  output logic [31:0]      dp_y2,
  output logic [31:0]      dp_y3,
  input  logic [31:0]      dp_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + PIPE_LAT + 2) + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  logic [1:0]        lane;
  logic              mode_q;
  logic [31:0]       stg_x [4];
  logic [31:0]       stg_y [4];

  logic [31:0]       dx_q [4];
  logic [31:0]       dy_q [4];
  logic [31:0]       dx_d [4];
  logic [31:0]       dy_d [4];
  logic              op_q;
  logic              grp_mode;

  logic [TAG_W-1:0]  tag_q;

  logic [PIPE_LAT:0] trk_v;
  logic [TAG_W-1:0]  trk_tag [PIPE_LAT+1];

  logic [31:0]       mem_z   [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic [CW-1:0]     inflight;
  logic              acc;
  logic              issue;
  logic              push;
  logic              pop;

  // Every tracked group owns one FIFO slot until it is read, so the
  // sum of tracked groups and stored results can never exceed depth.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= PIPE_LAT; i++) begin
      inflight = inflight + CW'(trk_v[i]);
    end
  end

  assign in_ready = (inflight + CW'(count)) < DEPTH_C;

  assign acc   = in_valid & in_ready;
  assign issue = acc & ((lane == 2'd3) | in_last);

  assign grp_mode = (lane == 2'd0) ? in_mode : mode_q;

  // Lanes below the current one come from staging, the current lane
  // takes the incoming pair, and unused lanes are padded with +0.0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dx_d[i] = '0;
      dy_d[i] = '0;
      if (2'(i) == lane) begin
        dx_d[i] = in_x;
        dy_d[i] = in_y;
      end else if (2'(i) < lane) begin
        dx_d[i] = stg_x[i];
        dy_d[i] = stg_y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane   <= '0;
      mode_q <= 1'b0;
      op_q   <= 1'b0;
      tag_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        stg_x[i] <= '0;
        stg_y[i] <= '0;
        dx_q[i]  <= '0;
        dy_q[i]  <= '0;
      end
    end else if (acc) begin
      stg_x[lane] <= in_x;
      stg_y[lane] <= in_y;
      if (lane == 2'd0) begin
        mode_q <= in_mode;
      end
      if (issue) begin
        for (int i = 0; i < 4; i++) begin
          dx_q[i] <= dx_d[i];
          dy_q[i] <= dy_d[i];
        end
        op_q  <= grp_mode;
        lane  <= '0;
        tag_q <= tag_q + TAG_ONE;
      end else begin
        lane <= lane + 2'd1;
      end
    end
  end

  // One stage per pipe register plus one: the bit leaving the last
  // stage lines up with the edge on which dp_z holds that group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_v <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        trk_tag[i] <= '0;
      end
    end else begin
      trk_v      <= {trk_v[PIPE_LAT-1:0], issue};
      trk_tag[0] <= tag_q;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        trk_tag[i] <= trk_tag[i-1];
      end
    end
  end

  assign push      = trk_v[PIPE_LAT];
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_z[wr_ptr]   <= dp_z;
      mem_tag[wr_ptr] <= trk_tag[PIPE_LAT];
    end
  end

  assign out_z   = out_valid ? mem_z[rd_ptr]   : '0;
  assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;

  assign busy = (lane != 2'd0)
              | (inflight != '0)
              | out_valid;

  assign dp_op = op_q;
  assign dp_x0 = dx_q[0];
  assign dp_x1 = dx_q[1];
  assign dp_x2 = dx_q[2];
  assign dp_x3 = dx_q[3];
  assign dp_y0 = dy_q[0];
  assign dp_y1 = dy_q[1];
  assign dp_y2 = dy_q[2];
  assign dp_y3 = dy_q[3];

  no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    push |-> (count < CNT_MAX)
  );

endmodule

// File: doc/dp_operand_sequencer.md
Name: dp_operand_sequencer

Overview:
- Front end of the pipelined 4-lane dot-product unit: accepts a serial stream of (x, y) FP32 operand pairs over a valid/ready handshake.
- Packs each group of up to 4 pairs into the parallel x0..x3 / y0..y3 / op operand bus and tracks each issued group through the fixed-latency, non-stallable pipe.
- Captures the z result at the correct cycle into a tagged output FIFO with valid/ready.
- Credit-based flow control guarantees no result is ever dropped.

Parameters:
PIPE_LAT, 3, number of register stages in the dot-product pipe (z is valid PIPE_LAT edges after operands change)
FIFO_DEPTH, 4, output result FIFO entries (power of 2, >=2)
TAG_W, 4, width of per-group sequence tag

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept pair
in_x  input  32  FP32 x element
in_y  input  32  FP32 y element
in_last  input  1  pair closes the current group early
in_mode  input  1  op mode for group, sampled with first pair of group
dp_op  output  1  op to dot-product pipe
dp_x0..dp_x3  output  32 each  x operands to pipe
dp_y0..dp_y3  output  32 each  y operands to pipe
dp_z  input  32  result from pipe
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_z  output  32  FIFO head result
out_tag  output  TAG_W  FIFO head tag
busy  output  1  partial group, in-flight group or unread result present

Behaviour:
- Reset (rst=0, async): lane counter, staging regs, dp_* regs, dp_op, in-flight shift register, FIFO pointers/count and tag counter all cleared to 0.
  - Outputs during and after reset: out_valid=0, out_z=0, out_tag=0, busy=0, in_ready=1.
  - In-flight and buffered results are discarded.
- Credit: inflight = popcount of the tracking shift register; count = FIFO occupancy.
  - in_ready = (inflight + count < FIFO_DEPTH), combinational from registered state only, independent of in_valid, in_last and lane.
  - A pop in the same cycle does not grant credit until the next cycle.
- Accept = in_valid & in_ready. The pair is written to staging lane[lane]. When lane==0, in_mode is captured as the group mode; in_mode on later pairs is ignored.
- Issue occurs on the accept edge when lane==3 or in_last=1:
  - dp_x/y regs load staging lanes 0..lane-1 plus the incoming pair; higher lanes load 32'h0 (+0.0).
  - dp_op loads the group mode; lane returns to 0; the tag counter increments modulo 2^TAG_W.
  - A 1 tagged with the current tag enters the tracking shift register.
- Without an issue, lane increments and dp_* hold their values. dp_* always hold the last issued group.
- Tracking shift register: length PIPE_LAT+1; each stage carries a valid bit plus a tag. When a valid bit exits at edge E_issue+PIPE_LAT+1, dp_z and its tag are pushed into the FIFO. out_valid rises immediately after that edge.
- FIFO: out_z/out_tag show the head entry. Pop on out_valid & out_ready. Simultaneous push and pop is legal and leaves count unchanged. Credit makes overflow impossible; a push when full is a design error, flagged by assertion.
- Results leave the FIFO in issue order, tags strictly sequential.
- in_valid with in_ready=0: no state change; the producer must hold its data.
- busy = (lane!=0) | (inflight!=0) | (count!=0).

Test Plan:
- 4 pairs x=3F800000, y=40000000, out_ready=1 -> one issue, dp_x0..3=3F800000, dp_y0..3=40000000, dp_op=mode of first pair. out_valid rises exactly PIPE_LAT+1 edges after the 4th accept, with out_z=41000000 (8.0) and out_tag=0.
- 2 pairs (40000000,3F800000), (40400000,3F800000), second with in_last=1 -> dp_x2,dp_x3,dp_y2,dp_y3=0. Result 40A00000 (5.0), tag 0, then lane=0.
- out_ready=0, stream 32 pairs -> exactly 4 groups issued, then in_ready=0 with FIFO full. Raise out_ready -> 8 results, tags 0..7 in order, none lost or duplicated.
- 17 back-to-back groups with TAG_W=4 -> 17th result carries tag 0. Sustained throughput of one pair per cycle while out_ready=1.
- First pair in_mode=1, rest in_mode=0 -> dp_op=1 for that group. Next group starting with in_mode=0 -> dp_op=0.
- Assert rst with 2 groups in flight and 1 result queued -> out_valid=0, busy=0 immediately. After release, the next group yields tag 0 and no stale results appear.
